// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM receive demultiplexer.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } tdm_state_e;

    localparam int unsigned NCH_DEFAULT = 8;

    // Bit offset of channel k inside a flat bank of w-bit samples.
    function automatic int unsigned ch_offset(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: wraps NCH-1 -> 0, can be cleared or loaded to 1 for realignment.
module tdm_slot_counter #(
    parameter int unsigned NCH   = 8,
    parameter int unsigned SEL_W = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load1_i,
    input  logic             inc_i,
    output logic [SEL_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [SEL_W-1:0] cnt_q, cnt_d;

    assign tc_o  = (cnt_q == SEL_W'(NCH - 1));
    assign cnt_o = cnt_q;

    // Next count: clear wins over realign, realign wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load1_i) begin
            cnt_d = SEL_W'(1);
        end else if (inc_i) begin
            cnt_d = tc_o ? '0 : cnt_q + SEL_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tdm_demux_1x8.sv
// TDM receive demux: gathers one frame of samples in a shadow bank and
// publishes it to the channel outputs atomically when the frame completes.
module tdm_demux_1x8
    import tdm_pkg::*;
#(
    parameter  int unsigned W     = 1,
    parameter  int unsigned NCH   = NCH_DEFAULT,
    localparam int unsigned SEL_W = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [W-1:0]       din,
    input  logic               din_valid,
    input  logic               frame_sync,
    output logic [NCH*W-1:0]   ch_data,
    output logic               frame_valid,
    output logic               sync_err,
    output logic               locked,
    output logic [SEL_W-1:0]   slot
);

    tdm_state_e       state_q, state_d;
    logic [NCH*W-1:0] shadow_q, shadow_d;
    logic [NCH*W-1:0] ch_data_q, ch_data_d;
    logic             frame_valid_q, sync_err_q;

    logic [SEL_W-1:0] slot_w;
    logic [SEL_W-1:0] wr_idx;
    logic             slot_tc;
    logic             wr_en, wr_ch0;
    logic             ctr_clr, ctr_load1, ctr_inc;
    logic             err_set, frame_done;

    tdm_slot_counter #(
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (ctr_clr),
        .load1_i (ctr_load1),
        .inc_i   (ctr_inc),
        .cnt_o   (slot_w),
        .tc_o    (slot_tc)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: only accepted samples move the FSM.
    always_comb begin
        state_d = state_q;
        if (din_valid) begin
            case (state_q)
                HUNT:    if (frame_sync) state_d = LOCK;
                LOCK:    if (!frame_sync && (slot_w == '0)) state_d = HUNT;
                default: state_d = HUNT;
            endcase
        end
    end

    // FSM outputs: shadow writes, counter controls and pulse requests.
    always_comb begin
        wr_en      = 1'b0;
        wr_ch0     = 1'b0;
        ctr_clr    = 1'b0;
        ctr_load1  = 1'b0;
        ctr_inc    = 1'b0;
        err_set    = 1'b0;
        frame_done = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        wr_en     = 1'b1;
                        wr_ch0    = 1'b1;
                        ctr_load1 = 1'b1;
                    end
                end
                LOCK: begin
                    if (frame_sync) begin
                        // Sync always restarts the frame; it is an error only mid-frame.
                        wr_en     = 1'b1;
                        wr_ch0    = 1'b1;
                        ctr_load1 = 1'b1;
                        err_set   = (slot_w != '0);
                    end else if (slot_w == '0) begin
                        err_set = 1'b1;
                        ctr_clr = 1'b1;
                    end else begin
                        wr_en      = 1'b1;
                        ctr_inc    = 1'b1;
                        frame_done = slot_tc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_idx = wr_ch0 ? '0 : slot_w;

    // Shadow bank update; the output bank takes the shadow including the final sample.
    always_comb begin
        shadow_d = shadow_q;
        if (wr_en) begin
            shadow_d[ch_offset(32'(wr_idx), W) +: W] = din;
        end
        ch_data_d = frame_done ? shadow_d : ch_data_q;
    end

    // Datapath and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q      <= '0;
            ch_data_q     <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            ch_data_q     <= ch_data_d;
            frame_valid_q <= frame_done;
            sync_err_q    <= err_set;
        end
    end

    assign ch_data     = ch_data_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == LOCK);
    assign slot        = slot_w;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Self-checking bench for tdm_demux_1x8 (W=1, NCH=8).
module tb_tdm_demux_1x8;

    localparam int unsigned W     = 1;
    localparam int unsigned NCH   = 8;
    localparam int unsigned SEL_W = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [W-1:0]       din = '0;
    logic               din_valid = 1'b0;
    logic               frame_sync = 1'b0;
    logic [NCH*W-1:0]   ch_data;
    logic               frame_valid;
    logic               sync_err;
    logic               locked;
    logic [SEL_W-1:0]   slot;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    tdm_demux_1x8 #(
        .W   (W),
        .NCH (NCH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .ch_data     (ch_data),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .locked      (locked),
        .slot        (slot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       s;
        logic       d;
        logic [7:0] ch;
        logic       fv;
        logic       err;
        logic       lk;
        logic [2:0] sl;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, s, d, input logic [7:0] ch,
                       input logic fv, err, lk, input logic [2:0] sl);
        vec_t r;
        r.v = v; r.s = s; r.d = d; r.ch = ch; r.fv = fv; r.err = err; r.lk = lk; r.sl = sl;
        tbl.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the current partial frame is a queue of accepted samples,
    // so its length is the expected slot; a full queue is a completed frame.
    logic             mq[$];
    bit               m_lock;
    logic [NCH*W-1:0] m_ch;
    bit               m_fv;
    bit               m_err;

    task automatic model_reset();
        mq.delete();
        m_lock = 0;
        m_ch   = '0;
        m_fv   = 0;
        m_err  = 0;
    endtask

    task automatic model_step(input logic v, s, d);
        m_fv  = 0;
        m_err = 0;
        if (v) begin
            if (s) begin
                if (m_lock && mq.size() != 0) m_err = 1;
                mq.delete();
                mq.push_back(d);
                m_lock = 1;
            end else if (m_lock) begin
                if (mq.size() == 0) begin
                    m_err  = 1;
                    m_lock = 0;
                end else begin
                    mq.push_back(d);
                    if (mq.size() == NCH) begin
                        for (int i = 0; i < NCH; i++) m_ch[i] = mq[i];
                        m_fv = 1;
                        mq.delete();
                    end
                end
            end
        end
    endtask

    task automatic check_model();
        check("ch_data",     32'(ch_data),     32'(m_ch));
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("sync_err",    32'(sync_err),    32'(m_err));
        check("locked",      32'(locked),      32'(m_lock));
        check("slot",        32'(slot),        32'(mq.size()));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ch_data"},     32'(ch_data),     32'h0);
        check({tag, ".frame_valid"}, 32'(frame_valid), 32'h0);
        check({tag, ".sync_err"},    32'(sync_err),    32'h0);
        check({tag, ".locked"},      32'(locked),      32'h0);
        check({tag, ".slot"},        32'(slot),        32'h0);
    endtask

    task automatic step(input logic v, s, d);
        @(negedge clk);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step_model(input logic v, s, d);
        step(v, s, d);
        model_step(v, s, d);
        check_model();
    endtask

    task automatic reset_release();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic pat [8];
        int   fv_cnt;
        logic v, s, d;

        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // Power-up reset.
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        reset_release();

        // HUNT: 5 samples without sync are dropped.
        add(1, 0, 1, 8'h00, 0, 0, 0, 3'd0);
        add(1, 0, 0, 8'h00, 0, 0, 0, 3'd0);
        add(1, 0, 1, 8'h00, 0, 0, 0, 3'd0);
        add(1, 0, 1, 8'h00, 0, 0, 0, 3'd0);
        add(1, 0, 0, 8'h00, 0, 0, 0, 3'd0);
        // Clean frame 1,0,1,1,0,0,1,0 -> 8'b0100_1101.
        add(1, 1, 1, 8'h00, 0, 0, 1, 3'd1);
        add(1, 0, 0, 8'h00, 0, 0, 1, 3'd2);
        add(1, 0, 1, 8'h00, 0, 0, 1, 3'd3);
        add(1, 0, 1, 8'h00, 0, 0, 1, 3'd4);
        add(1, 0, 0, 8'h00, 0, 0, 1, 3'd5);
        add(1, 0, 0, 8'h00, 0, 0, 1, 3'd6);
        add(1, 0, 1, 8'h00, 0, 0, 1, 3'd7);
        add(1, 0, 0, 8'h4D, 1, 0, 1, 3'd0);
        add(0, 1, 1, 8'h4D, 0, 0, 1, 3'd0);
        // Partial frame, then early sync at slot 5 realigns.
        add(1, 1, 0, 8'h4D, 0, 0, 1, 3'd1);
        add(1, 0, 0, 8'h4D, 0, 0, 1, 3'd2);
        add(1, 0, 0, 8'h4D, 0, 0, 1, 3'd3);
        add(1, 0, 0, 8'h4D, 0, 0, 1, 3'd4);
        add(1, 0, 0, 8'h4D, 0, 0, 1, 3'd5);
        add(1, 1, 1, 8'h4D, 0, 1, 1, 3'd1);
        add(1, 0, 1, 8'h4D, 0, 0, 1, 3'd2);
        add(1, 0, 1, 8'h4D, 0, 0, 1, 3'd3);
        add(1, 0, 0, 8'h4D, 0, 0, 1, 3'd4);
        add(1, 0, 0, 8'h4D, 0, 0, 1, 3'd5);
        add(1, 0, 1, 8'h4D, 0, 0, 1, 3'd6);
        add(1, 0, 1, 8'h4D, 0, 0, 1, 3'd7);
        add(1, 0, 1, 8'hE7, 1, 0, 1, 3'd0);
        // Missing sync at slot 0: error, back to HUNT, prior frame kept.
        add(1, 0, 1, 8'hE7, 0, 1, 0, 3'd0);
        add(1, 0, 1, 8'hE7, 0, 0, 0, 3'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].d);
            check("tbl.ch_data",     32'(ch_data),     32'(tbl[i].ch));
            check("tbl.frame_valid", 32'(frame_valid), 32'(tbl[i].fv));
            check("tbl.sync_err",    32'(sync_err),    32'(tbl[i].err));
            check("tbl.locked",      32'(locked),      32'(tbl[i].lk));
            check("tbl.slot",        32'(slot),        32'(tbl[i].sl));
        end

        // Asynchronous reset mid-frame clears everything without a clock edge.
        step(1, 1, 1);
        step(1, 0, 1);
        step(1, 0, 0);
        @(negedge clk);
        din_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        reset_release();
        model_reset();

        // Gapped input: three frames of the clean pattern with idle cycles between samples.
        fv_cnt = 0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NCH; i++) begin
                step_model(1'b1, (i == 0), pat[i]);
                if (frame_valid) fv_cnt++;
                step_model(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                if (frame_valid) fv_cnt++;
            end
        end
        check("gapped.ch_data", 32'(ch_data), 32'h4D);
        check("gapped.pulses",  32'(fv_cnt),  32'd3);

        // Randomised traffic: mostly well-formed framing with occasional sync faults.
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(0, 3) != 0);
            s = (mq.size() == 0);
            if ($urandom_range(0, 11) == 0) s = ~s;
            d = 1'($urandom_range(0, 1));
            step_model(v, s, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
